// File: rtl/yarp_pkg.sv
// rtl/yarp_pkg.sv - shared constants for the YARP instruction fetch path
//
// Purpose: error response word, legal parameter ranges and the response
// payload width used by yarp_instr_mem and yarp_resp_pipe.
// Ports: none (package).

package yarp_pkg;

  // Error responses carry a NOP (addi x0, x0, 0) so a core that ignores
  // the error flag still executes something harmless.
  localparam logic [31:0] YARP_INSTR_ERR_DATA = 32'h0000_0013;

  localparam int YARP_LATENCY_MIN = 1;
  localparam int YARP_LATENCY_MAX = 4;

  localparam int YARP_DEPTH_MIN = 16;
  localparam int YARP_DEPTH_MAX = 65536;

  // Response payload is {err, data}.
  localparam int YARP_RESP_W = 33;

  function automatic bit yarp_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/yarp_resp_pipe.sv
// rtl/yarp_resp_pipe.sv - fixed-length response delay line
//
// Purpose: delays a {valid, payload} response by STAGES cycles. Valid bits
// are asynchronously cleared; payload registers have no reset and are
// forced to zero at the output whenever valid is low.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   valid_i  - response valid in
//   data_i   - response payload in (WIDTH bits)
//   valid_o  - response valid out, STAGES cycles later
//   data_o   - response payload out, zero when valid_o is low

module yarp_resp_pipe #(
  parameter int WIDTH  = 33,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (STAGES == 0) begin : g_wire
      assign valid_o = valid_i;
      assign data_o  = valid_i ? data_i : '0;
    end else begin : g_pipe
      logic [STAGES-1:0] valid_q;
      logic [WIDTH-1:0]  data_q [STAGES];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= valid_i;
          for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        data_q[0] <= data_i;
        for (int i = 1; i < STAGES; i++) begin
          data_q[i] <= data_q[i-1];
        end
      end

      assign valid_o = valid_q[STAGES-1];
      assign data_o  = valid_o ? data_q[STAGES-1] : '0;
    end
  endgenerate

endmodule

// File: rtl/yarp_instr_mem.sv
// rtl/yarp_instr_mem.sv - instruction memory with fixed-latency fetch port
//
// Purpose: word-addressed instruction store. Fetch requests are always
// accepted and answered in order exactly LATENCY cycles later; a backdoor
// load port writes program words. Misaligned or out-of-range fetches get an
// error response carrying a NOP; such loads are dropped.
// Ports:
//   clk               - clock, rising edge
//   reset             - asynchronous active-low reset
//   instr_mem_req_i   - fetch request strobe
//   instr_mem_addr_i  - fetch byte address
//   mem_rd_data_o     - returned instruction word (0 when not valid)
//   mem_rd_valid_o    - response valid
//   mem_rd_err_o      - response is an error (0 when not valid)
//   load_en_i         - backdoor write strobe
//   load_addr_i       - backdoor byte address
//   load_data_i       - backdoor write data

module yarp_instr_mem
  import yarp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_mem_req_i,
  input  logic [31:0] instr_mem_addr_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_rd_valid_o,
  output logic        mem_rd_err_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  generate
    if (LATENCY < YARP_LATENCY_MIN || LATENCY > YARP_LATENCY_MAX) begin : g_bad_latency
      $error("yarp_instr_mem: LATENCY must be within 1..4");
    end
    if (DEPTH_WORDS < YARP_DEPTH_MIN || DEPTH_WORDS > YARP_DEPTH_MAX ||
        !yarp_is_pow2(DEPTH_WORDS)) begin : g_bad_depth
      $error("yarp_instr_mem: DEPTH_WORDS must be a power of two within 16..65536");
    end
    if ((BASE_ADDR % (DEPTH_WORDS * 4)) != 0) begin : g_bad_base
      $error("yarp_instr_mem: BASE_ADDR must be aligned to DEPTH_WORDS*4 bytes");
    end
  endgenerate

  // Offsets wrap in 32 bits, so an address below BASE_ADDR lands far above
  // the array and fails the upper-bits check instead of aliasing. Because
  // BASE_ADDR is word aligned, offset[1:0] equals the address low bits.
  logic [31:0]      req_off;
  logic [31:0]      load_off;
  logic             req_ok;
  logic             load_ok;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] load_idx;

  assign req_off  = instr_mem_addr_i - BASE_ADDR;
  assign req_ok   = (req_off[1:0] == 2'b00) && (req_off[31:IDX_W+2] == '0);
  assign req_idx  = req_off[IDX_W+1:2];

  assign load_off = load_addr_i - BASE_ADDR;
  assign load_ok  = reset && load_en_i &&
                    (load_off[1:0] == 2'b00) && (load_off[31:IDX_W+2] == '0);
  assign load_idx = load_off[IDX_W+1:2];

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        s1_valid_q;
  logic        s1_err_q;
  logic [31:0] s1_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= instr_mem_req_i;
    end
  end

  // Read and write share one edge; non-blocking semantics give the old word
  // to a same-cycle fetch of the word being loaded.
  always_ff @(posedge clk) begin
    if (instr_mem_req_i) begin
      s1_err_q <= !req_ok;
      if (req_ok) begin
        s1_data_q <= mem_q[req_idx];
      end else begin
        s1_data_q <= YARP_INSTR_ERR_DATA;
      end
    end
    if (load_ok) begin
      mem_q[load_idx] <= load_data_i;
    end
  end

  logic [YARP_RESP_W-1:0] resp;

  yarp_resp_pipe #(
    .WIDTH  (YARP_RESP_W),
    .STAGES (LATENCY - 1)
  ) u_resp_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (s1_valid_q),
    .data_i  ({s1_err_q, s1_data_q}),
    .valid_o (mem_rd_valid_o),
    .data_o  (resp)
  );

  assign mem_rd_err_o  = resp[32];
  assign mem_rd_data_o = resp[31:0];

endmodule

// File: tb/tb_yarp_instr_mem.sv
// tb/tb_yarp_instr_mem.sv - bench for yarp_instr_mem at latencies 1, 3 and 2

module tb_yarp_instr_mem;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic [31:0] rd_data  [3];
  logic        rd_valid [3];
  logic        rd_err   [3];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Instance 0: defaults. Instance 1: 16 words, latency 3.
  // Instance 2: 16 words at 0x40, latency 2.
  yarp_instr_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
    .mem_rd_data_o(rd_data[0]), .mem_rd_valid_o(rd_valid[0]), .mem_rd_err_o(rd_err[0]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

  yarp_instr_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
    .mem_rd_data_o(rd_data[1]), .mem_rd_valid_o(rd_valid[1]), .mem_rd_err_o(rd_err[1]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

  yarp_instr_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h40), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
    .mem_rd_data_o(rd_data[2]), .mem_rd_valid_o(rd_valid[2]), .mem_rd_err_o(rd_err[2]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_depth(input int k);
    return (k == 0) ? 1024 : 16;
  endfunction

  function automatic logic [31:0] p_base(input int k);
    return (k == 2) ? 32'h40 : 32'h0;
  endfunction

  function automatic int p_lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  // Plain-arithmetic address map: word index of a byte address, or 0 if the
  // address is misaligned or beyond the stored words.
  function automatic bit map_addr(input int k, input logic [31:0] a, output int idx);
    logic [31:0] off;
    off = a - p_base(k);
    idx = 0;
    if ((a % 4) != 0) return 1'b0;
    if (off >= 32'(p_depth(k) * 4)) return 1'b0;
    idx = int'(off / 4);
    return 1'b1;
  endfunction

  // Model state: word store per instance and a schedule of what each
  // instance must show on every cycle.
  logic [31:0] m_mem   [3][1024];
  bit          m_known [3][1024];
  bit          ev [3][4096];
  bit          ee [3][4096];
  logic [31:0] ed [3][4096];
  bit          ek [3][4096];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        for (int k = 0; k < 3; k++) begin
          int  idx;
          int  slot;
          bit  ok;
          if (req) begin
            ok   = map_addr(k, addr, idx);
            slot = cyc + p_lat(k) - 1;
            ev[k][slot] = 1'b1;
            if (ok) begin
              ee[k][slot] = 1'b0;
              ed[k][slot] = m_mem[k][idx];
              ek[k][slot] = m_known[k][idx];
            end else begin
              ee[k][slot] = 1'b1;
              ed[k][slot] = 32'h0000_0013;
              ek[k][slot] = 1'b1;
            end
          end
          if (load_en && map_addr(k, load_addr, idx)) begin
            m_mem[k][idx]   = load_data;
            m_known[k][idx] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit          xv;
        bit          xe;
        logic [31:0] xd;
        bit          data_ok;
        if (!reset) begin
          for (int c = cyc; c < cyc + 5; c++) ev[k][c] = 1'b0;
        end
        xv = ev[k][cyc];
        xe = xv ? ee[k][cyc] : 1'b0;
        xd = xv ? ed[k][cyc] : 32'h0;
        data_ok = (xv && !ek[k][cyc]) ? 1'b1 : (rd_data[k] === xd);
        n_vec++;
        if (rd_valid[k] !== xv || rd_err[k] !== xe || !data_ok) begin
          n_bad++;
          $display("FAIL cmp inst%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   k, cyc, rd_valid[k], rd_err[k], rd_data[k], xv, xe, xd);
        end
      end
    end
  end

  task automatic expect_resp(input string nm, input int k, input bit v, input bit e,
                             input logic [31:0] d);
    n_vec++;
    if ({rd_valid[k], rd_err[k], rd_data[k]} !== {v, e, d}) begin
      n_bad++;
      $display("FAIL %s inst%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
               nm, k, rd_valid[k], rd_err[k], rd_data[k], v, e, d);
    end
  endtask

  task automatic step(input bit rq, input logic [31:0] ra, input bit ld,
                      input logic [31:0] la, input logic [31:0] lv);
    @(posedge clk);
    #1;
    req       = rq;
    addr      = ra;
    load_en   = ld;
    load_addr = la;
    load_data = lv;
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'hAAAA_0001;
      1:       return 32'hBBBB_0002;
      2:       return 32'h1111_1111;
      default: return 32'h5000_0000 + 32'(i) * 32'h0101;
    endcase
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return 32'($urandom_range(0, 159)) | 32'h1;
    return 32'($urandom_range(0, 39)) * 4;
  endfunction

  initial begin
    reset = 1'b0; req = 1'b0; addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) expect_resp("reset_idle", k, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) expect_resp("reset_req_ignored", k, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 32; i++) step(1'b0, 32'h0, 1'b1, 32'(i * 4), init_word(i));

    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("b2b_first", 0, 1'b1, 1'b0, 32'hAAAA_0001);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("b2b_second", 0, 1'b1, 1'b0, 32'hBBBB_0002);

    step(1'b1, 32'h2, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("misaligned", 0, 1'b1, 1'b1, 32'h0000_0013);

    step(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("top_of_space", 0, 1'b1, 1'b1, 32'h0000_0013);

    step(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("depth16_oob", 1, 1'b1, 1'b1, 32'h0000_0013);

    step(1'b1, 32'h8, 1'b1, 32'h8, 32'h2222_2222);
    step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("rbw_old", 0, 1'b1, 1'b0, 32'h1111_1111);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("rbw_new", 0, 1'b1, 1'b0, 32'h2222_2222);

    for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("lat3_first", 1, 1'b1, 1'b0, 32'hAAAA_0001);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("lat3_second", 1, 1'b1, 1'b0, 32'hBBBB_0002);
    #1 reset = 1'b0;
    #1 expect_resp("reset_drop", 1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) expect_resp("reread_after_reset", 1, 1'b1, 1'b0, 32'hAAAA_0001);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), pick_addr(),
           1'($urandom_range(0, 9) < 3), pick_addr(), $urandom());
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/yarp_instr_mem.md
YARP_INSTR_MEM -- requirements
Module: yarp_instr_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored (power of two, 16..65536).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 The block SHALL have parameter LATENCY, default 1, meaning the request-to-response cycles (legal range 1..4).
REQ-004 Port clk, input, 1, clock; all logic on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port instr_mem_req_i, input, 1, fetch request strobe from the fetch unit.
REQ-007 Port instr_mem_addr_i, input, 32, fetch byte address (PC).
REQ-008 Port mem_rd_data_o, output, 32, returned instruction word.
REQ-009 Port mem_rd_valid_o, output, 1, mem_rd_data_o valid this cycle.
REQ-010 Port mem_rd_err_o, output, 1, response is an error (misaligned or out of range).
REQ-011 Port load_en_i, input, 1, backdoor write strobe for program loading.
REQ-012 Port load_addr_i, input, 32, backdoor byte address.
REQ-013 Port load_data_i, input, 32, backdoor write data.

Function
REQ-014 Every cycle with instr_mem_req_i=1 SHALL be accepted; there is no back-pressure, and one response SHALL be issued per request.
REQ-015 A request accepted at edge N SHALL produce mem_rd_valid_o=1 exactly LATENCY cycles later, with responses in request order and back-to-back requests giving back-to-back responses.
REQ-016 Word index SHALL be (addr - BASE_ADDR) >> 2, using unsigned 32-bit subtraction that wraps.
REQ-017 A request with addr[1:0]!=0, or with an index >= DEPTH_WORDS, SHALL respond with mem_rd_err_o=1 and mem_rd_data_o=YARP_INSTR_ERR_DATA; the array SHALL NOT be read.
REQ-018 Valid non-error responses SHALL return the word stored at the index with mem_rd_err_o=0.
REQ-019 When mem_rd_valid_o=0, mem_rd_data_o SHALL be 32'h0 and mem_rd_err_o SHALL be 0.
REQ-020 A load write with load_en_i=1 SHALL update the array at edge, using the same index and range rules; misaligned or out-of-range loads SHALL be silently dropped.
REQ-021 A same-cycle load and request to the same index SHALL return the old data (read-before-write); the new data SHALL be visible to requests from the next cycle.
REQ-022 The read SHALL be synchronous in stage 1; stages 2..LATENCY SHALL be a pure delay line carrying {valid, err, data}.
REQ-023 Address 32'hFFFF_FFFC with BASE_ADDR=0 SHALL be treated as out of range, with no index aliasing.

Reset
REQ-024 While reset=0, all pipeline valid bits SHALL clear asynchronously, so mem_rd_valid_o=0, mem_rd_err_o=0 and mem_rd_data_o=0.
REQ-025 Array contents SHALL NOT be reset and SHALL retain their values through reset.
REQ-026 Requests in flight when reset asserts SHALL be discarded, with no response after reset deasserts.
REQ-027 Requests and loads SHALL be ignored while reset=0.

Structure
REQ-028 YARP_INSTR_ERR_DATA (32'h0000_0013, NOP) and the LATENCY legal bounds SHALL live in shared package yarp_pkg.
REQ-029 The delay line SHALL be sub-module yarp_resp_pipe (parameters WIDTH, STAGES), with an asynchronously reset valid and a non-reset payload except as required by REQ-019.
REQ-030 Parameter violations SHALL be flagged by elaboration-time assertions.

Verification
REQ-031 Load 0x0->32'hAAAA_0001 and 0x4->32'hBBBB_0002, then request 0x0 and 0x4 on consecutive cycles (LATENCY=1) -> valid on two consecutive cycles with data AAAA_0001 then BBBB_0002, err=0.
REQ-032 Request 0x2 -> one cycle later valid=1, err=1, data=32'h0000_0013; array unchanged.
REQ-033 DEPTH_WORDS=16: request 0x40 -> err=1; load to 0x40 -> no array word changes.
REQ-034 Array 0x8=32'h1111_1111; same cycle load 0x8=32'h2222_2222 and request 0x8, then request 0x8 again -> responses 1111_1111 then 2222_2222.
REQ-035 LATENCY=3 with requests on 3 consecutive cycles, reset asserted after the 2nd response -> valid drops immediately, no 3rd response after release, array contents intact on re-read.
REQ-036 LATENCY=2 with random request/load streams against a scoreboard -> every response matches in order, with exact 2-cycle latency.
